// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select generation and load-use hazard detection for the
// decode stage of the 4-stage pipeline; tracks EX and WB destination info.
module fwd_hazard_unit #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs_a,
  input  logic [RA_W-1:0]  id_rs_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, LDSTALL = 1'b1} state_t;

  state_t          state;
  logic            ex_v, ex_wr, ex_ld;
  logic [RA_W-1:0] ex_rd;
  logic            wb_v, wb_wr;
  logic [RA_W-1:0] wb_rd;
  logic            hazard;

  // A load in EX has no result yet, so it can only be forwarded once it reaches WB.
  function automatic logic [1:0] fwd_sel(
    input logic            use_x,
    input logic [RA_W-1:0] rs,
    input logic            exv,
    input logic            exw,
    input logic            exl,
    input logic [RA_W-1:0] exrd,
    input logic            wbv,
    input logic            wbw,
    input logic [RA_W-1:0] wbrd
  );
    if (use_x && exv && exw && !exl && (exrd == rs))
      return 2'd1;
    else if (use_x && wbv && wbw && (wbrd == rs))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    forward_a = fwd_sel(id_use_a, id_rs_a, ex_v, ex_wr, ex_ld, ex_rd, wb_v, wb_wr, wb_rd);
    forward_b = fwd_sel(id_use_b, id_rs_b, ex_v, ex_wr, ex_ld, ex_rd, wb_v, wb_wr, wb_rd);
    hazard    = id_valid && !flush && ex_v && ex_wr && ex_ld &&
                ((id_use_a && (ex_rd == id_rs_a)) || (id_use_b && (ex_rd == id_rs_b)));
    stall     = hazard && (state == RUN);
  end

  // ID -> EX -> WB stage advance, load-use FSM and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v        <= 1'b0;
      ex_rd       <= '0;
      ex_wr       <= 1'b0;
      ex_ld       <= 1'b0;
      wb_v        <= 1'b0;
      wb_rd       <= '0;
      wb_wr       <= 1'b0;
      state       <= RUN;
      stall_count <= '0;
    end else begin
      wb_v  <= ex_v;
      wb_rd <= ex_rd;
      wb_wr <= ex_wr;
      ex_v  <= id_valid && !stall && !flush;
      ex_rd <= id_rd;
      ex_wr <= id_wr_en;
      ex_ld <= id_is_load;
      case (state)
        RUN:     if (stall) state <= LDSTALL;
        LDSTALL: state <= RUN;
        default: state <= RUN;
      endcase
      if (stall) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit: forwarding priority, load-use
// stall, flush, unused operands, async reset and counter saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_rs_a, id_rs_b, id_rd;
  logic        id_use_a, id_use_b, id_wr_en, id_is_load, flush;
  logic [1:0]  forward_a, forward_b, forward_a_s, forward_b_s;
  logic        stall, stall_s;
  logic [15:0] stall_count;
  logic [1:0]  stall_count_s;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.RA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.RA_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .forward_a(forward_a_s), .forward_b(forward_b_s),
    .stall(stall_s), .stall_count(stall_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive the decode slot, then let combinational outputs settle.
  task automatic id(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                    input logic ua, input logic ub, input logic [3:0] rd,
                    input logic wr, input logic ld, input logic fl);
    id_valid = v; id_rs_a = ra; id_rs_b = rb; id_use_a = ua; id_use_b = ub;
    id_rd = rd; id_wr_en = wr; id_is_load = ld; flush = fl;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_fa", forward_a, 0);
    chk("rst_fb", forward_b, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_count, 0);
    #10 rst_n = 1'b1;
    step();

    // Back-to-back ALU dependency
    id(1, 0, 0, 0, 0, 3, 1, 0, 0);            // ADD r3
    chk("add_stall", stall, 0);
    step();
    id(1, 3, 4, 1, 1, 6, 1, 0, 0);            // SUB r6 <- r3, r4
    chk("b2b_fa", forward_a, 1);
    chk("b2b_fb", forward_b, 0);
    chk("b2b_stall", stall, 0);
    step();
    id(1, 3, 6, 1, 1, 7, 0, 0, 0);            // r3 now in WB, r6 in EX
    chk("mix_fa_wb", forward_a, 2);
    chk("mix_fb_ex", forward_b, 1);
    nop();
    nop();

    // Distance-2 dependency and EX-over-WB priority
    id(1, 0, 0, 0, 0, 5, 1, 0, 0);  step();   // ADD r5
    nop();
    id(1, 0, 5, 0, 1, 5, 1, 0, 0);            // uses r5, writes r5
    chk("d2_fb", forward_b, 2);
    step();
    id(1, 0, 5, 0, 1, 5, 1, 0, 0);
    chk("d1_fb", forward_b, 1);
    step();
    id(1, 5, 5, 1, 0, 0, 1, 0, 0);            // EX and WB both r5; writes r0
    chk("prio_fa", forward_a, 1);
    chk("unused_fb", forward_b, 0);
    step();
    id(1, 0, 0, 1, 1, 1, 1, 0, 0);            // r0 forwarded like any register
    chk("r0_fa", forward_a, 1);
    chk("r0_same_fb", forward_b, 1);
    nop();
    nop();

    // Load-use hazard
    id(1, 0, 0, 0, 0, 2, 1, 1, 0);            // LOAD r2
    chk("ld_stall0", stall, 0);
    step();
    id(1, 2, 0, 1, 0, 7, 1, 0, 0);
    chk("lu_stall", stall, 1);
    chk("lu_fa_ld_ex", forward_a, 0);
    chk("lu_cnt_before", stall_count, 0);
    step();
    id(1, 2, 0, 1, 0, 7, 1, 0, 0);            // consumer held in decode
    chk("ldst_stall", stall, 0);
    chk("ldst_fa", forward_a, 2);
    chk("ldst_cnt", stall_count, 1);
    chk("ldst_cnt_s", stall_count_s, 1);
    step();
    id(1, 7, 0, 1, 0, 0, 0, 0, 0);            // consumer advanced to EX
    chk("post_fa", forward_a, 1);
    chk("post_stall", stall, 0);
    nop();
    nop();

    // Flush wins over hazard
    id(1, 0, 0, 0, 0, 2, 1, 1, 0);  step();   // LOAD r2
    id(1, 2, 0, 1, 0, 9, 1, 0, 1);
    chk("fl_stall", stall, 0);
    step();
    id(1, 2, 2, 1, 1, 9, 0, 0, 0);
    chk("fl_cnt", stall_count, 1);
    chk("fl_fa", forward_a, 2);
    chk("fl_fb", forward_b, 2);
    chk("fl_stall2", stall, 0);
    nop();
    nop();

    // No-write producer and unused operands
    id(1, 0, 0, 0, 0, 4, 0, 0, 0);  step();   // rd=r4, no write
    id(1, 4, 4, 1, 1, 0, 0, 0, 0);
    chk("nowr_fa", forward_a, 0);
    chk("nowr_fb", forward_b, 0);
    nop();
    nop();
    id(1, 0, 0, 0, 0, 8, 1, 1, 0);  step();   // LOAD r8
    id(1, 8, 8, 0, 0, 0, 0, 0, 0);
    chk("unused_ld_stall", stall, 0);
    chk("unused_ld_fa", forward_a, 0);
    nop();
    nop();

    // Four more load-use stalls: 16-bit count reaches 5, 2-bit count saturates at 3
    for (int i = 0; i < 4; i++) begin
      id(1, 0, 0, 0, 0, 2, 1, 1, 0);  step();
      id(1, 0, 2, 0, 1, 7, 1, 0, 0);
      chk("sat_stall", stall, 1);
      step();
      id(1, 0, 2, 0, 1, 7, 1, 0, 0);
      chk("sat_fb", forward_b, 2);
      step();
      chk("sat_cnt", stall_count, 32'(2 + i));
      chk("sat_cnt_s", stall_count_s, (2 + i > 3) ? 3 : 32'(2 + i));
    end
    nop();

    // Asynchronous reset between edges
    id(1, 0, 0, 0, 0, 1, 1, 0, 0);  step();   // ADD r1
    id(1, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_fa", forward_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fa", forward_a, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_cnt", stall_count, 0);
    chk("mid_rst_cnt_s", stall_count_s, 0);
    rst_n = 1'b1;
    step();
    chk("after_rst_fa", forward_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
